// File: rtl/checksum_verify.sv
// checksum_verify: receive-side one's-complement checksum check.
// Sums a 32-bit big-endian frame (plus a pseudo-header seed) into a 32-bit
// accumulator, folds it to 16 bits and reports pass when the fold is 0xFFFF.
module checksum_verify (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic [15:0] i_seed,
  input  logic [31:0] i_tdata,
  input  logic [3:0]  i_tkeep,
  input  logic        i_tvalid,
  input  logic        i_tlast,
  output logic        o_tready,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic        o_ok,
  output logic [15:0] o_sum,
  output logic [15:0] o_checksum
);

  typedef enum logic [1:0] {RUN, FOLD, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] acc;
  logic        first;
  logic [15:0] sum;
  logic [31:0] masked;
  logic [31:0] base;
  logic [16:0] s1;
  logic        beat;
  logic        res_hs;

  assign o_tready    = (state == RUN);
  assign o_res_valid = (state == DONE);
  assign beat        = i_tvalid & o_tready & ~i_clear;
  assign res_hs      = o_res_valid & i_res_ready;

  // Zero any byte lane whose keep bit is low (odd-length tails).
  always_comb begin
    masked = '0;
    for (int b = 0; b < 4; b++)
      masked[8*b +: 8] = i_tkeep[b] ? i_tdata[8*b +: 8] : 8'h00;
  end

  // Seed replaces the running sum on the first beat of a frame.
  always_comb begin
    base = first ? {16'b0, i_seed} : acc;
  end

  // First fold of the accumulator; the end-around carry is added when the
  // result is registered on the FOLD->DONE edge.
  always_comb begin
    s1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
  end

  // Next-state logic; clear wins over every other event.
  always_comb begin
    state_nxt = state;
    if (i_clear) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (beat && i_tlast) state_nxt = FOLD;
        FOLD:    state_nxt = DONE;
        DONE:    if (i_res_ready) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= RUN;
    else          state <= state_nxt;
  end

  // Accumulator, first-beat flag and registered result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc   <= '0;
      first <= 1'b1;
      sum   <= '0;
    end else if (i_clear) begin
      acc   <= '0;
      first <= 1'b1;
    end else begin
      if (beat) begin
        acc   <= base + {16'b0, masked[31:16]} + {16'b0, masked[15:0]};
        first <= 1'b0;
      end
      if (state == FOLD)
        sum <= s1[15:0] + {15'b0, s1[16]};
      if (res_hs) begin
        acc   <= '0;
        first <= 1'b1;
      end
    end
  end

  assign o_sum      = sum;
  assign o_ok       = (sum == 16'hFFFF);
  assign o_checksum = ~sum;

endmodule

// File: tb/tb_checksum_verify.sv
// Scoreboard bench for checksum_verify: stimulus pushes model results,
// a monitor pops and compares on every result handshake.
module tb_checksum_verify;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] seed = '0;
  logic [31:0] tdata = '0;
  logic [3:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        ok;
  logic [15:0] sum;
  logic [15:0] checksum;

  int n_chk = 0;
  int n_pass = 0;
  int gap_max = 0;
  int ready_mode = 1;   // 0 low, 1 high, 2 random
  logic [15:0] sb[$];

  checksum_verify dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_seed(seed),
    .i_tdata(tdata), .i_tkeep(tkeep), .i_tvalid(tvalid), .i_tlast(tlast),
    .o_tready(tready), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_ok(ok), .o_sum(sum), .o_checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: sum of big-endian 16-bit words of the kept bytes plus seed,
  // folded with end-around carry until it fits in 16 bits.
  function automatic logic [15:0] model(input logic [15:0] sd,
                                        input logic [31:0] w[$], input logic [3:0] k[$]);
    longint s = sd;
    for (int i = 0; i < w.size(); i++) begin
      logic [7:0] by[4];
      for (int b = 0; b < 4; b++)
        by[b] = k[i][3-b] ? w[i][31-8*b -: 8] : 8'h00;
      s += {by[0], by[1]};
      s += {by[2], by[3]};
    end
    while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  // Result-ready driver.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: res_ready = 1'b0;
      1: res_ready = 1'b1;
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: one comparison set per result handshake.
  initial forever begin
    @(negedge clk);
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        logic [15:0] e, ce;
        e = sb.pop_front();
        ce = ~e;
        chk("sum", sum, e);
        chk("ok", ok, (e == 16'hFFFF));
        chk("checksum", checksum, ce);
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    logic rdy;
    repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    do begin
      @(negedge clk); rdy = tready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 2000);
    if (!rdy) chk("accept_timeout", 0, 1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] sd, input logic [31:0] w[$],
                            input logic [3:0] k[$], input bit push);
    if (push) sb.push_back(model(sd, w, k));
    seed = sd;
    for (int i = 0; i < w.size(); i++)
      send_beat(w[i], k[i], i == w.size() - 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [31:0] hdr[$]  = '{32'h45000073, 32'h00004000, 32'h4011B861, 32'hC0A80001, 32'hC0A800C7};
  logic [31:0] hdr0[$] = '{32'h45000073, 32'h00004000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7};
  logic [3:0]  k5[$]   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  initial begin
    logic [31:0] w[$];
    logic [3:0]  k[$];
    logic [15:0] exp_a;
    int n;

    // Reset state, before any clock edge.
    #1;
    chk("rst_tready", tready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_ok", ok, 0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_checksum", checksum, 16'hFFFF);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // IPv4 header, with latency check.
    ready_mode = 1;
    send_frame(16'h0000, hdr, k5, 1);
    @(negedge clk); chk("lat_fold_valid", res_valid, 0);
    @(negedge clk); chk("lat_done_valid", res_valid, 1);
    drain();

    // Checksum field zeroed: expected sum 0x479E.
    chk("model_479e", model(16'h0, hdr0, k5), 16'h479E);
    send_frame(16'h0000, hdr0, k5, 1);
    drain();

    // Odd length, then with compensating seed; empty beat returns seed.
    w = '{32'hABCDEF12}; k = '{4'b1110};
    send_frame(16'h0000, w, k, 1);
    send_frame(16'h6531, w, k, 1);
    k = '{4'b0000};
    send_frame(16'h1234, w, k, 1);
    w = '{32'h0}; k = '{4'hF};
    send_frame(16'h0000, w, k, 1);
    drain();

    // Clear mid-frame; the beat presented with clear must be ignored.
    send_beat(32'hDEADBEEF, 4'hF, 1'b0);
    send_beat(32'h12345678, 4'hF, 1'b0);
    clear = 1'b1; tvalid = 1'b1; tdata = 32'hFFFF0000; tkeep = 4'hF;
    @(posedge clk); #1;
    clear = 1'b0; tvalid = 1'b0;
    send_frame(16'h0000, hdr, k5, 1);
    drain();

    // Backpressure: result held 10 cycles with the next frame waiting.
    ready_mode = 0;
    @(posedge clk); #1;
    w = '{}; k = '{};
    for (int i = 0; i < 3; i++) begin w.push_back($urandom); k.push_back(4'hF); end
    exp_a = model(16'hA5A5, w, k);
    send_frame(16'hA5A5, w, k, 1);
    n = 0;
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_result_seen", res_valid, 1);
    w = '{32'h11112222, 32'h33334444}; k = '{4'hF, 4'b1100};
    seed = 16'h0F0F; tdata = w[0]; tkeep = k[0]; tlast = 1'b0; tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_tready", tready, 0);
      chk("bp_valid", res_valid, 1);
      chk("bp_sum", sum, exp_a);
    end
    ready_mode = 1;
    gap_max = 0;
    send_frame(16'h0F0F, w, k, 1);
    drain();

    // Randomized frames with gaps and random result backpressure.
    ready_mode = 2;
    gap_max = 3;
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(1, 12);
      w = '{}; k = '{};
      for (int i = 0; i < len; i++) begin
        w.push_back($urandom);
        k.push_back(i == len - 1 ? 4'($urandom) : 4'hF);
      end
      send_frame(16'($urandom), w, k, 1);
    end
    drain();

    // Maximum length, random valid gaps.
    ready_mode = 1;
    gap_max = 1;
    w = '{}; k = '{};
    for (int i = 0; i < 16384; i++) begin w.push_back(32'hFFFFFFFF); k.push_back(4'hF); end
    send_frame(16'h0000, w, k, 1);
    drain();

    // Reset during FOLD: outputs return to reset values without a clock.
    gap_max = 0;
    w = '{32'h01020304}; k = '{4'hF};
    send_frame(16'h0000, w, k, 0);
    rst_n = 1'b0;
    #1;
    chk("rstfold_valid", res_valid, 0);
    chk("rstfold_tready", tready, 1);
    chk("rstfold_checksum", checksum, 16'hFFFF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(16'h0000, hdr, k5, 1);
    drain();

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
